scalar_reg_write_arbiter: RTL and testbench

// Shares the single write port of the scalar register bank (16 x 32-bit) between two writeback

---
 rtl/scalar_reg_write_arbiter.sv | 86 ++++++++
 tb/tb_scalar_reg_write_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/scalar_reg_write_arbiter.sv
// Round-robin arbiter sharing the scalar register bank write port between ALU and load writeback.
// The granted write is registered into the bank one cycle later; RAW hazards are flagged for two read ports.
module scalar_reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  bank_we,
  output logic [ADDR_WIDTH-1:0] bank_wa,
  output logic [DATA_WIDTH-1:0] bank_wd,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  logic                  ptr_p0;
  logic                  grant0_p0;
  logic                  grant1_p0;
  logic                  vld_p0;
  logic                  both_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic raw_hit(input logic [ADDR_WIDTH-1:0] ra);
    return (bank_we && (ra == bank_wa)) ||
           (req0_valid && (ra == req0_addr)) ||
           (req1_valid && (ra == req1_addr));
  endfunction

  // p0: grant selection; ptr_p0=0 favours req0 when both are valid
  always_comb begin
    both_p0   = req0_valid & req1_valid;
    grant0_p0 = ~rst & req0_valid & (~req1_valid | ~ptr_p0);
    grant1_p0 = ~rst & req1_valid & (~req0_valid | ptr_p0);
    vld_p0    = grant0_p0 | grant1_p0;
    addr_p0   = grant1_p0 ? req1_addr : req0_addr;
    data_p0   = grant1_p0 ? req1_data : req0_data;
  end

  assign req0_ready = grant0_p0;
  assign req1_ready = grant1_p0;
  assign hazard1    = raw_hit(ra1);
  assign hazard2    = raw_hit(ra2);

  // p0 -> p1: bank write stage, pointer and conflict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p0       <= 1'b0;
      bank_we      <= 1'b0;
      bank_wa      <= '0;
      bank_wd      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant0_p0) begin
        ptr_p0 <= 1'b1;
      end else if (grant1_p0) begin
        ptr_p0 <= 1'b0;
      end
      bank_we <= vld_p0;
      if (vld_p0) begin
        bank_wa <= addr_p0;
        bank_wd <= data_p0;
      end
      if (both_p0) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

endmodule

// File: tb/tb_scalar_reg_write_arbiter.sv
// Bench for scalar_reg_write_arbiter: directed scenarios plus random traffic against a
// behavioural model (favoured side, pending bank write, register contents, conflict count).
module tb_scalar_reg_write_arbiter;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0v, r1v;
  logic [3:0]  r0a, r1a, ra1, ra2;
  logic [31:0] r0d, r1d;
  logic        ready0, ready1, hazard1, hazard2, bank_we;
  logic [3:0]  bank_wa;
  logic [31:0] bank_wd;
  logic [CW-1:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit          m_fav;
  bit          m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  int          m_cnt;
  logic [31:0] m_reg [16];
  bit          acc0, acc1;

  logic [31:0] mem [16] = '{default: 32'd0};

  scalar_reg_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(ready0),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(ready1),
    .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
    .bank_we(bank_we), .bank_wa(bank_wa), .bank_wd(bank_wd),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bank_we) mem[bank_wa] <= bank_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads_pending(input logic [3:0] ra);
    return (m_we && ra == m_wa) || (r0v && ra == r0a) || (r1v && ra == r1a);
  endfunction

  // Compare at the falling edge, then advance the model to what the next rising edge does.
  task automatic check_and_model();
    bit g0, g1;
    if (rst) begin
      m_fav = 0; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
    end
    g0 = !rst && r0v && (!r1v || !m_fav);
    g1 = !rst && r1v && !g0;
    chk("ready0", ready0, g0);
    chk("ready1", ready1, g1);
    chk("bank_we", bank_we, m_we);
    chk("bank_wa", bank_wa, m_wa);
    chk("bank_wd", bank_wd, m_wd);
    chk("hazard1", hazard1, reads_pending(ra1));
    chk("hazard2", hazard2, reads_pending(ra2));
    chk("conflict_cnt", conflict_cnt, m_cnt);
    acc0 = g0;
    acc1 = g1;
    if (!rst) begin
      if (m_we) m_reg[m_wa] = m_wd;
      m_we = g0 || g1;
      if (g0) begin m_wa = r0a; m_wd = r0d; m_fav = 1; end
      if (g1) begin m_wa = r1a; m_wd = r1d; m_fav = 0; end
      if (r0v && r1v && m_cnt < SAT) m_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] old6;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_fav = 0; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
    rst = 1'b1;
    r0v = 1; r0a = 4'd1; r0d = 32'd15;
    r1v = 0; r1a = 0; r1d = 0;
    ra1 = 4'd1; ra2 = 4'd0;
    #2;
    chk("rst_ready0", ready0, 0);
    chk("rst_we", bank_we, 0);
    chk("rst_cnt", conflict_cnt, 0);
    step();
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("first_grant", ready0, 1);
    step();
    r0v = 0;
    #1 chk("single_we", bank_we, 1);
    chk("single_wa", bank_wa, 1);
    chk("single_wd", bank_wd, 15);
    step();
    chk("single_commit", mem[1], 15);

    // alternating grants under contention
    do_reset();
    r0v = 1; r0a = 4'd1; r0d = 32'd15;
    r1v = 1; r1a = 4'd2; r1d = 32'd23;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("contend_wa", bank_wa, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    r0v = 0; r1v = 0;
    #1 chk("contend_cnt", conflict_cnt, 4);
    step();

    // same destination from both sides, pointer at req0
    do_reset();
    r0v = 1; r0a = 4'd3; r0d = 32'd7;
    r1v = 1; r1a = 4'd3; r1d = 32'd9;
    step();
    r0v = 0;
    chk("same_first", bank_wd, 7);
    step();
    r1v = 0;
    chk("same_second", bank_wd, 9);
    step();
    step();
    chk("same_final", mem[3], 9);

    // hazard on a pending load writeback
    do_reset();
    r1v = 1; r1a = 4'd5; r1d = 32'h55; ra2 = 4'd5; ra1 = 4'd0;
    #1 chk("haz_pending", hazard2, 1);
    step();
    r1v = 0;
    #1 chk("haz_inflight", hazard2, 1);
    step();
    chk("haz_cleared", hazard2, 0);

    // reset taken while a write is in the output stage
    old6 = mem[6];
    r0v = 1; r0a = 4'd6; r0d = 32'hDEAD_BEEF;
    step();
    r0v = 0;
    chk("midrst_we_before", bank_we, 1);
    rst = 1'b1;
    #1 chk("midrst_we_drop", bank_we, 0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_reg", mem[6], old6);
    r0v = 1; r1v = 1; r0a = 4'd8; r1a = 4'd9;
    #1 chk("midrst_ptr", ready0, 1);
    step();

    // saturation of the conflict counter
    do_reset();
    r0v = 1; r1v = 1;
    for (int i = 0; i < SAT + 8; i++) begin
      r0d = $urandom; r1d = $urandom;
      step();
    end
    chk("cnt_sat", conflict_cnt, SAT);
    r0v = 0; r1v = 0;
    step();

    // random traffic with held requests
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (acc0) r0v = 0;
      if (acc1) r1v = 0;
      if (!r0v && $urandom_range(0, 9) < 6) begin
        r0v = 1; r0a = 4'($urandom_range(0, 15)); r0d = $urandom;
      end
      if (!r1v && $urandom_range(0, 9) < 6) begin
        r1v = 1; r1a = 4'($urandom_range(0, 15)); r1d = $urandom;
      end
      ra1 = 4'($urandom_range(0, 15));
      ra2 = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; r0v = 0; r1v = 0;
    step();
    step();
    for (int i = 0; i < 16; i++) chk("reg_contents", mem[i], m_reg[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
